t06_wall_query_scanner: RTL
===========================

Name: t06_wall_query_scanner

Overview:
- Sequential consumer of the wall wrapper's `wall_locations` (25 slots × {y,x}) and border limits (`xmax`/`xmin`/`ymax`/`ymin`).
- Answers tile-occupancy queries from the display/renderer and next-head logic through a valid/ready request/response handshake.
- On each accepted request it snapshots the wall set, scans it one slot per cycle, and reports border hit, wall hit and the index of the hit slot.
- It replaces a 25-way parallel comparator with a small serial FSM.

Parameters:
- NUM_WALLS, 25, number of wall slots in `wall_locations`.
- COORD_W, 4, width of one x or y coordinate.

Ports:
- system_clk  in  1  system clock; all state changes on its rising edge.
- nrst  in  1  asynchronous, active-high reset (1 = clear). Named per codebase convention; the polarity is active-high regardless of the name.
- req_valid  in  1  query request present.
- req_ready  out  1  block can accept a query.
- req_x  in  COORD_W  queried tile x.
- req_y  in  COORD_W  queried tile y.
- wall_locations  in  NUM_WALLS*8  slot i = bits [8i+7:8i] = {y[3:0], x[3:0]}; 8'h00 = empty slot.
- xmax, xmin, ymax, ymin  in  COORD_W each  current play-field limits.
- resp_valid  out  1  response present.
- resp_ready  in  1  consumer takes the response.
- resp_wall  out  1  queried tile matches a non-empty wall slot.
- resp_border  out  1  tile is on or outside the border: x>=xmax | y>=ymax | x<=xmin | y<=ymin.
- resp_index  out  5  matching slot index; 5'h1F if there is no slot hit.

Behaviour:
- Reset (nrst=1, async): state=IDLE, resp_valid=0, resp_wall=0, resp_border=0, resp_index=5'h1F, scan index=0, snapshot cleared. req_ready=1 immediately after reset deasserts.
- FSM states: IDLE, SCAN, RESP. req_ready=1 only in IDLE. resp_valid=1 only in RESP.
- IDLE: on req_valid (cycle T), capture req_x, req_y and the full wall_locations snapshot.
  - Evaluate the border from the live limits in cycle T.
  - Border hit: resp_border=1, resp_wall=0, resp_index=1F, next state RESP. resp_valid is high at T+1.
  - Otherwise: idx=0, next state SCAN.
- SCAN: each cycle compare snapshot slot[idx] against {y,x}. Empty slots (8'h00) never match.
  - Match: resp_wall=1, resp_index=idx, next state RESP.
  - No match and idx==NUM_WALLS-1: resp_wall=0, resp_index=1F, next state RESP.
  - Otherwise: idx+1.
- Latency, measured from the accept edge:
  - Hit at slot k: response at T+2+k.
  - Full miss: response at T+1+NUM_WALLS (T+26).
  - Lowest-index match wins; the scan exits early.
- RESP: hold all resp_* stable while resp_ready=0. On resp_valid&resp_ready go to IDLE. req_ready returns the cycle after the handshake, so there is no same-cycle back-to-back accept.
- Snapshot isolation: changes to wall_locations or the limits after accept do not affect the in-flight query.
- Reset mid-SCAN or mid-RESP: the response is dropped, the block returns to IDLE, and no resp_valid pulse is issued.
- idx is a 5-bit counter and never exceeds NUM_WALLS-1.

Decomposition:
- Package t06_wall_pkg: state enum {IDLE, SCAN, RESP}, NUM_WALLS, EMPTY_SLOT=8'h00, NO_INDEX=5'h1F.
- Sub-module t06_wall_slot_mux: purely combinational. Selects the 8-bit slot[idx] from the snapshot and outputs match = (slot=={y,x}) & (slot!=EMPTY_SLOT).
- The FSM, counter and handshake registers live in the top module.

Test Plan:
- Reset check: assert nrst mid-SCAN → resp_valid=0 that cycle, req_ready=1 after release, resp_index=1F.
- Border query: xmin=2, query x=2, y=5 → resp_valid at T+1, resp_border=1, resp_wall=0, resp_index=1F.
- Wall hit: slot 7={y=6,x=9}, query (9,6) with limits 1..14 → resp_valid at T+9, resp_wall=1, resp_index=7. Duplicate in slot 12 → index stays 7.
- Miss with empties: all slots 8'h00 except slot 3={4,4}, query (5,5) → resp_valid at T+26, resp_wall=0, resp_border=0, resp_index=1F. Query (0,0) gives resp_border=1 and never matches an empty slot.
- Snapshot/backpressure: change wall_locations during the scan → the result reflects the old set. Hold resp_ready=0 for 10 cycles → outputs stable, req_ready=0. Release → req_ready=1 on the next cycle.

Source files
------------

// File: rtl/t06_wall_pkg.sv
// Shared constants and FSM state type for the wall query scanner.
package t06_wall_pkg;
    localparam int         NUM_WALLS  = 25;
    localparam int         COORD_W    = 4;
    localparam logic [7:0] EMPTY_SLOT = 8'h00;
    localparam logic [4:0] NO_INDEX   = 5'h1F;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        SCAN = 2'd1,
        RESP = 2'd2
    } state_t;
endpackage

// File: rtl/t06_wall_slot_mux.sv
// Selects one 8-bit wall slot from the snapshot and tests it against the queried tile.
module t06_wall_slot_mux
    import t06_wall_pkg::*;
#(
    parameter int N_SLOTS = t06_wall_pkg::NUM_WALLS,
    parameter int CW      = t06_wall_pkg::COORD_W
) (
    input  logic [N_SLOTS*8-1:0] snapshot,
    input  logic [4:0]           idx,
    input  logic [CW-1:0]        qx,
    input  logic [CW-1:0]        qy,
    output logic                 match
);
    logic [7:0] slot;

    // An out-of-range index reads as an empty slot, so it can never match.
    always_comb begin
        slot = EMPTY_SLOT;
        for (int i = 0; i < N_SLOTS; i++) begin
            if (idx == i[4:0]) slot = snapshot[8*i +: 8];
        end
    end

    assign match = (slot == {qy, qx}) && (slot != EMPTY_SLOT);
endmodule

// File: rtl/t06_wall_query_scanner.sv
// Serial wall/border occupancy query: snapshot the wall set on accept, scan one slot per cycle.
module t06_wall_query_scanner
    import t06_wall_pkg::*;
#(
    parameter int NUM_WALLS = t06_wall_pkg::NUM_WALLS,
    parameter int COORD_W   = t06_wall_pkg::COORD_W
) (
    input  logic                   system_clk,
    input  logic                   nrst,
    input  logic                   req_valid,
    output logic                   req_ready,
    input  logic [COORD_W-1:0]     req_x,
    input  logic [COORD_W-1:0]     req_y,
    input  logic [NUM_WALLS*8-1:0] wall_locations,
    input  logic [COORD_W-1:0]     xmax,
    input  logic [COORD_W-1:0]     xmin,
    input  logic [COORD_W-1:0]     ymax,
    input  logic [COORD_W-1:0]     ymin,
    output logic                   resp_valid,
    input  logic                   resp_ready,
    output logic                   resp_wall,
    output logic                   resp_border,
    output logic [4:0]             resp_index,
    output logic [1:0]             dbg_state
);
    localparam logic [4:0] LAST_IDX = 5'(NUM_WALLS - 1);

    state_t                 state_q, state_d;
    logic [4:0]             idx_q, idx_d;
    logic [NUM_WALLS*8-1:0] snap_q, snap_d;
    logic [COORD_W-1:0]     qx_q, qx_d, qy_q, qy_d;
    logic                   wall_q, wall_d, border_q, border_d;
    logic [4:0]             index_q, index_d;
    logic                   slot_match;
    logic                   border_hit;

    t06_wall_slot_mux #(
        .N_SLOTS (NUM_WALLS),
        .CW      (COORD_W)
    ) u_slot_mux (
        .snapshot (snap_q),
        .idx      (idx_q),
        .qx       (qx_q),
        .qy       (qy_q),
        .match    (slot_match)
    );

    assign border_hit = (req_x >= xmax) || (req_y >= ymax) ||
                        (req_x <= xmin) || (req_y <= ymin);

    always_ff @(posedge system_clk or posedge nrst) begin
        if (nrst) begin
            state_q  <= IDLE;
            idx_q    <= '0;
            snap_q   <= '0;
            qx_q     <= '0;
            qy_q     <= '0;
            wall_q   <= 1'b0;
            border_q <= 1'b0;
            index_q  <= NO_INDEX;
        end else begin
            state_q  <= state_d;
            idx_q    <= idx_d;
            snap_q   <= snap_d;
            qx_q     <= qx_d;
            qy_q     <= qy_d;
            wall_q   <= wall_d;
            border_q <= border_d;
            index_q  <= index_d;
        end
    end

    // Handshakes: a transfer happens on a rising edge where valid && ready are both high;
    // a valid side holds its payload stable until that edge, ready never waits on valid.
    always_comb begin
        state_d  = state_q;
        idx_d    = idx_q;
        snap_d   = snap_q;
        qx_d     = qx_q;
        qy_d     = qy_q;
        wall_d   = wall_q;
        border_d = border_q;
        index_d  = index_q;
        unique case (state_q)
            IDLE: begin
                if (req_valid) begin
                    snap_d   = wall_locations;
                    qx_d     = req_x;
                    qy_d     = req_y;
                    wall_d   = 1'b0;
                    index_d  = NO_INDEX;
                    border_d = border_hit;
                    idx_d    = '0;
                    state_d  = border_hit ? RESP : SCAN;
                end
            end
            SCAN: begin
                if (slot_match) begin
                    wall_d  = 1'b1;
                    index_d = idx_q;
                    state_d = RESP;
                end else if (idx_q == LAST_IDX) begin
                    wall_d  = 1'b0;
                    index_d = NO_INDEX;
                    state_d = RESP;
                end else begin
                    idx_d = idx_q + 5'd1;
                end
            end
            RESP: begin
                if (resp_ready) state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    assign req_ready   = (state_q == IDLE);
    assign resp_valid  = (state_q == RESP);
    assign resp_wall   = wall_q;
    assign resp_border = border_q;
    assign resp_index  = index_q;
    assign dbg_state   = state_q;
endmodule
